// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encodings and sizing helpers.
// Any 2-bit code not listed in state_t is treated as IDLE by the consumers.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter needs at least one bit even for a single-bit datapath.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell; the only arithmetic in the serial adder datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic ca
);

    assign sum = a ^ b ^ cin;
    assign ca  = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell reused LSB-first over WIDTH cycles,
// with a start/done handshake and registered sum/cout that hold the last completed result.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_sum;
    logic             fa_ca;
    logic             accept;
    logic             last_bit;

    full_adder fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .sum (fa_sum),
        .ca  (fa_ca)
    );

    // Start is honoured in every state except RUN (the unused code 3 behaves as IDLE).
    assign accept   = start && (state != ST_RUN);
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign acc_next = WIDTH'({fa_sum, acc} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_RUN:  next_state = last_bit ? ST_DONE : ST_RUN;
            default: next_state = start ? ST_RUN : ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            acc   <= '0;
            cnt   <= '0;
            carry <= cin;
        end else if (state == ST_RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            acc   <= acc_next;
            carry <= fa_ca;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                sum  <= acc_next;
                cout <= fa_ca;
            end
        end
    end

endmodule
